// File: rtl/gesture_uart_rx_if.sv
// Signal bundle between the gesture UART receiver and its host-side driver/observer.
// slave = receiver side, master = side that drives rx and watches the gesture outputs.
interface gesture_uart_rx_if;
   logic       rx;
   logic [7:0] gesture;
   logic       gesture_strobe;
   logic       frame_err;
   logic [7:0] err_count;

   modport master (output rx, input gesture, gesture_strobe, frame_err, err_count);
   modport slave  (input rx, output gesture, gesture_strobe, frame_err, err_count);
endinterface

// File: rtl/gesture_uart_rx.sv
// UART gesture-frame receiver: 8N1 bit FSM feeding a frame FSM (A5, code[, ~code]).
// Optional checksum byte is enabled by defining GESTURE_RX_CHECKSUM_EN.
//
// bit FSM    | meaning
// B_IDLE     | line idle, waiting for a synchronized falling edge
// B_START    | half-bit wait, then confirm the start bit is still low
// B_DATA     | eight mid-bit samples, LSB first
// B_STOP     | mid-bit stop sample, then straight back to idle
//
// frame FSM    | meaning
// F_WAIT_SYNC  | hunting for the 0xA5 sync byte
// F_WAIT_CODE  | sync seen, expecting a gesture code
// F_WAIT_CHECK | code latched, expecting its complement (checksum build only)
module gesture_uart_rx #(
   parameter int CLK_HZ        = 50000000,
   parameter int BAUD          = 115200,
   parameter int MAX_CODE      = 11,
   parameter int FRAME_TIMEOUT = 100000
) (
   input  logic               clk,
   input  logic               reset,
   gesture_uart_rx_if.slave   bus
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int OW = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [OW-1:0] TO_LOAD   = OW'(FRAME_TIMEOUT - 1);
   localparam logic [7:0]    SYNC_BYTE = 8'hA5;
   localparam logic [7:0]    MAX_LEGAL = 8'(MAX_CODE);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
   typedef enum logic [1:0] {F_WAIT_SYNC, F_WAIT_CODE, F_WAIT_CHECK} frame_state_t;

   logic rx_s1, rx_s2, rx_d, rx_fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= bus.rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign rx_fall = rx_d & ~rx_s2;

   bit_state_t    bit_state, bit_next;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_tick, byte_done_c, stop_bad_c;
   logic          byte_valid, stop_err;

   assign bit_tick = (bit_timer == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bit_state <= B_IDLE;
      else       bit_state <= bit_next;
   end

   always_comb begin
      bit_next = bit_state;
      case (bit_state)
         B_IDLE:  if (rx_fall) bit_next = B_START;
         B_START: if (bit_tick) bit_next = rx_s2 ? B_IDLE : B_DATA;
         B_DATA:  if (bit_tick && bit_idx == 3'd7) bit_next = B_STOP;
         B_STOP:  if (bit_tick) bit_next = B_IDLE;
         default: bit_next = B_IDLE;
      endcase
   end

   always_comb begin
      byte_done_c = 1'b0;
      stop_bad_c  = 1'b0;
      if (bit_state == B_STOP && bit_tick) begin
         byte_done_c = rx_s2;
         stop_bad_c  = ~rx_s2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_timer  <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         byte_valid <= byte_done_c;
         stop_err   <= stop_bad_c;
         case (bit_state)
            B_IDLE: if (rx_fall) bit_timer <= HALF_LOAD;
            B_START, B_STOP: begin
               if (bit_tick) begin
                  bit_timer <= BIT_LOAD;
                  bit_idx   <= '0;
               end else begin
                  bit_timer <= bit_timer - TW'(1);
               end
            end
            B_DATA: begin
               if (bit_tick) begin
                  bit_timer <= BIT_LOAD;
                  bit_idx   <= bit_idx + 3'd1;
                  shreg     <= {rx_s2, shreg[7:1]};
               end else begin
                  bit_timer <= bit_timer - TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   frame_state_t  frame_state, frame_next;
   logic [OW-1:0] to_cnt;
   logic          timeout, code_legal, accept_c, err_c;
   logic          accept_q, err_q;
   logic [7:0]    accept_code, accept_code_q;

   assign code_legal = (shreg != 8'd0) && (shreg <= MAX_LEGAL);
   // byte_valid wins over an expiring timer so a byte arriving on the last cycle still counts
   assign timeout = (frame_state != F_WAIT_SYNC) && (to_cnt == '0) && !byte_valid;

`ifdef GESTURE_RX_CHECKSUM_EN
   logic [7:0] code_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         code_q <= '0;
      else if (frame_state == F_WAIT_CODE && frame_next == F_WAIT_CHECK)
         code_q <= shreg;
   end

   assign accept_code = code_q;
`else
   assign accept_code = shreg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_state <= F_WAIT_SYNC;
      else       frame_state <= frame_next;
   end

   always_comb begin
      frame_next = frame_state;
      if (stop_err || timeout) begin
         frame_next = F_WAIT_SYNC;
      end else if (byte_valid) begin
         case (frame_state)
            F_WAIT_SYNC: if (shreg == SYNC_BYTE) frame_next = F_WAIT_CODE;
            F_WAIT_CODE: begin
               if (shreg == SYNC_BYTE)
                  frame_next = F_WAIT_CODE;
`ifdef GESTURE_RX_CHECKSUM_EN
               else if (code_legal)
                  frame_next = F_WAIT_CHECK;
`endif
               else
                  frame_next = F_WAIT_SYNC;
            end
            default: frame_next = F_WAIT_SYNC;
         endcase
      end
   end

   always_comb begin
      accept_c = 1'b0;
      err_c    = 1'b0;
      if (stop_err || timeout) begin
         err_c = 1'b1;
      end else if (byte_valid) begin
         case (frame_state)
            F_WAIT_CODE: begin
               if (shreg != SYNC_BYTE) begin
`ifdef GESTURE_RX_CHECKSUM_EN
                  err_c = ~code_legal;
`else
                  accept_c = code_legal;
                  err_c    = ~code_legal;
`endif
               end
            end
`ifdef GESTURE_RX_CHECKSUM_EN
            F_WAIT_CHECK: begin
               accept_c = (shreg == ~code_q);
               err_c    = (shreg != ~code_q);
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (frame_state == F_WAIT_SYNC || byte_valid) begin
         to_cnt <= TO_LOAD;
      end else if (to_cnt != '0) begin
         to_cnt <= to_cnt - OW'(1);
      end
   end

   logic [7:0] gesture_q, err_count_q;
   logic       strobe_q, frame_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accept_q      <= 1'b0;
         err_q         <= 1'b0;
         accept_code_q <= '0;
         gesture_q     <= '0;
         strobe_q      <= 1'b0;
         frame_err_q   <= 1'b0;
         err_count_q   <= '0;
      end else begin
         accept_q    <= accept_c;
         err_q       <= err_c;
         if (accept_c) accept_code_q <= accept_code;
         strobe_q    <= accept_q;
         frame_err_q <= err_q;
         if (accept_q) gesture_q <= accept_code_q;
         if (err_q && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign bus.gesture        = gesture_q;
   assign bus.gesture_strobe = strobe_q;
   assign bus.frame_err      = frame_err_q;
   assign bus.err_count      = err_count_q;

endmodule
